// File: rtl/seq_divider_8bit_if.sv
// Operator-side signal bundle for the sequential divider.
// The master drives the switch operand and the Run/ClearA_LoadB levels.
// The slave returns the quotient/remainder registers and the status flags.
interface seq_divider_8bit_if #(
  parameter int WIDTH = 8
);
  logic             Run;
  logic             ClearA_LoadB;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             Done;
  logic             Busy;
  logic             DivZero;

  modport master (
    output Run, ClearA_LoadB, S,
    input  Q, R, Done, Busy, DivZero
  );

  modport slave (
    input  Run, ClearA_LoadB, S,
    output Q, R, Done, Busy, DivZero
  );
endinterface

// File: rtl/seq_divider_8bit.sv
// Unsigned restoring divider (shift / compare / subtract) with its control FSM.
// The dividend is loaded into Q from the switches.
// The divisor is captured from the switches in the LOAD cycle after Run.
// Each bit costs one SHIFT and one SUB cycle.
// After the final SUB, Q holds the quotient and R holds the remainder.
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  seq_divider_8bit_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SUB   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic             x_r;
  logic [CW-1:0]    count_r;
  logic             done_r;
  logic             busy_r;
  logic             divzero_r;

  // Trial subtraction of the divisor from the shifted partial remainder {X,R}.
  logic [WIDTH:0]   t_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;

  assign t_s    = {x_r, r_r};
  assign diff_s = t_s - {1'b0, d_r};
  assign ge_s   = (t_s >= {1'b0, d_r});

  assign bus.Q       = q_r;
  assign bus.R       = r_r;
  assign bus.Done    = done_r;
  assign bus.Busy    = busy_r;
  assign bus.DivZero = divzero_r;

  // State register; Done/Busy are registered alongside it as Moore flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == ST_HALT);
      busy_r  <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_SHIFT) ||
                 (state_nxt_s == ST_SUB);
    end
  end

  // Next-state logic; load wins over Run in IDLE, and HALT waits for Run to drop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ClearA_LoadB) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.Run) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.S == {WIDTH{1'b0}}) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        state_nxt_s = ST_SUB;
      end
      ST_SUB: begin
        if (count_r == CNT_LAST) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_HALT: begin
        if (bus.Run) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand loading, shift/subtract iterations and the divide-by-zero result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_r       <= {WIDTH{1'b0}};
      r_r       <= {WIDTH{1'b0}};
      d_r       <= {WIDTH{1'b0}};
      x_r       <= 1'b0;
      count_r   <= {CW{1'b0}};
      divzero_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (bus.ClearA_LoadB) begin
            q_r       <= bus.S;
            r_r       <= {WIDTH{1'b0}};
            x_r       <= 1'b0;
            divzero_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          d_r     <= bus.S;
          x_r     <= 1'b0;
          count_r <= {CW{1'b0}};
          if (bus.S == {WIDTH{1'b0}}) begin
            // The dividend is still sitting in Q, so it becomes the remainder.
            q_r       <= {WIDTH{1'b1}};
            r_r       <= q_r;
            divzero_r <= 1'b1;
          end else begin
            r_r       <= {WIDTH{1'b0}};
            divzero_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          x_r <= r_r[WIDTH-1];
          r_r <= {r_r[WIDTH-2:0], q_r[WIDTH-1]};
          q_r <= {q_r[WIDTH-2:0], 1'b0};
        end
        ST_SUB: begin
          x_r <= 1'b0;
          if (ge_s) begin
            r_r    <= diff_s[WIDTH-1:0];
            q_r[0] <= 1'b1;
          end
          if (count_r != CNT_LAST) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          x_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
